key_conditioner: RTL and testbench

//  Front-end for the traffic-light panel keys (plus, sub, ACC, mode) feeding the controller top level.
//  Per key: synchronise, debounce, detect press/release edges, and generate auto-repeat while held.
//  The controller consumes single-clk pulses instead of raw edge-detecting bouncing pins.

---
 rtl/key_conditioner_pkg.sv | 21 ++
 rtl/key_conditioner_channel.sv | 165 ++++++++++++++++
 rtl/key_conditioner.sv | 62 ++++++
 tb/tb_key_conditioner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/key_conditioner_pkg.sv
// rtl/key_conditioner_pkg.sv - shared state encodings and sizing helpers for the key conditioner
package key_conditioner_pkg;

    typedef logic [2:0] key_state_t;

    localparam key_state_t ST_IDLE     = 3'd0;
    localparam key_state_t ST_PRESS_DB = 3'd1;
    localparam key_state_t ST_HELD     = 3'd2;
    localparam key_state_t ST_REPEAT   = 3'd3;
    localparam key_state_t ST_REL_DB   = 3'd4;

    // Width of a counter that must hold 0..max_val; never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int cycles_per_ms(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/key_conditioner_channel.sv
// rtl/key_conditioner_channel.sv - one key: synchroniser, debounce/hold/repeat FSM and pulse registers
module key_conditioner_channel
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 800,
    parameter int REPEAT_MS   = 150,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic key_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o,
    output logic long_o
);

    localparam int DB_W   = cnt_width(DEBOUNCE_MS);
    localparam int HOLD_W = cnt_width(LONG_MS);
    localparam int REP_W  = cnt_width(REPEAT_MS);

    localparam logic [DB_W-1:0]   DB_LIM   = DB_W'(DEBOUNCE_MS);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(LONG_MS);
    localparam logic [REP_W-1:0]  REP_LIM  = REP_W'(REPEAT_MS);

    logic pressed_raw;
    logic meta_q, sync_q;

    key_state_t        state_q, state_d;
    logic [DB_W-1:0]   db_q, db_d, db_inc;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic [REP_W-1:0]  rep_q, rep_d, rep_inc;
    logic level_q, level_d, long_q, long_d;
    logic press_q, press_d, release_q, release_d, repeat_q, repeat_d;

    // Normalising before the flops lets reset clear the chain to "released" for either polarity.
    assign pressed_raw = key_raw_i ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= pressed_raw;
            sync_q <= meta_q;
        end
    end

    assign db_inc   = (db_q == DB_LIM)     ? db_q   : db_q + DB_W'(1);
    assign hold_inc = (hold_q == HOLD_LIM) ? hold_q : hold_q + HOLD_W'(1);
    assign rep_inc  = (rep_q == REP_LIM)   ? rep_q  : rep_q + REP_W'(1);

    always_comb begin
        state_d   = state_q;
        db_d      = db_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        level_d   = level_q;
        long_d    = long_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                db_d = '0;
                if (sync_q) state_d = ST_PRESS_DB;
            end
            ST_PRESS_DB: begin
                if (!sync_q) begin
                    state_d = ST_IDLE;
                    db_d    = '0;
                end else if (tick_i) begin
                    if (db_inc == DB_LIM) begin
                        state_d  = ST_HELD;
                        db_d     = '0;
                        hold_d   = '0;
                        level_d  = 1'b1;
                        press_d  = 1'b1;
                        repeat_d = 1'b1;
                    end else begin
                        db_d = db_inc;
                    end
                end
            end
            ST_HELD: begin
                if (!sync_q) begin
                    state_d = ST_REL_DB;
                    db_d    = '0;
                end else if (tick_i) begin
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_LIM) begin
                        state_d  = ST_REPEAT;
                        rep_d    = '0;
                        long_d   = 1'b1;
                        repeat_d = 1'b1;
                    end
                end
            end
            ST_REPEAT: begin
                if (!sync_q) begin
                    state_d = ST_REL_DB;
                    db_d    = '0;
                end else if (tick_i) begin
                    if (rep_inc == REP_LIM) begin
                        rep_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        rep_d = rep_inc;
                    end
                end
            end
            ST_REL_DB: begin
                // long_q is set exactly when REPEAT is entered, so it records where we came from.
                if (sync_q) begin
                    state_d = long_q ? ST_REPEAT : ST_HELD;
                end else if (tick_i) begin
                    if (db_inc == DB_LIM) begin
                        state_d   = ST_IDLE;
                        db_d      = '0;
                        level_d   = 1'b0;
                        long_d    = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        db_d = db_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            db_q      <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
            level_q   <= 1'b0;
            long_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_q      <= db_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            level_q   <= level_d;
            long_q    <= long_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level_o   = level_q;
    assign long_o    = long_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - 1 ms prescaler plus one conditioning channel per panel key
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS      = 4,
    parameter int CLK_HZ      = 12_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 800,
    parameter int REPEAT_MS   = 150,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw_i,
    output logic [N_KEYS-1:0] key_level_o,
    output logic [N_KEYS-1:0] key_press_o,
    output logic [N_KEYS-1:0] key_release_o,
    output logic [N_KEYS-1:0] key_repeat_o,
    output logic [N_KEYS-1:0] key_long_o,
    output logic              tick_1ms_o
);

    localparam int DIV   = cycles_per_ms(CLK_HZ);
    localparam int PRE_W = cnt_width(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    if (DEBOUNCE_MS < 1 || LONG_MS < 1 || REPEAT_MS < 1 || DIV < 1) begin : g_bad_params
        $error("key_conditioner: DEBOUNCE_MS, LONG_MS, REPEAT_MS must be >= 1 and CLK_HZ >= 1000");
    end

    logic [PRE_W-1:0] pre_q;
    logic             tick;

    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= tick ? '0 : pre_q + PRE_W'(1);
    end

    assign tick_1ms_o = tick;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_conditioner_channel #(
            .DEBOUNCE_MS(DEBOUNCE_MS),
            .LONG_MS    (LONG_MS),
            .REPEAT_MS  (REPEAT_MS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_i   (tick),
            .key_raw_i(key_raw_i[k]),
            .level_o  (key_level_o[k]),
            .press_o  (key_press_o[k]),
            .release_o(key_release_o[k]),
            .repeat_o (key_repeat_o[k]),
            .long_o   (key_long_o[k])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner at 10 clk per ms
module tb_key_conditioner;

    localparam int N = 4;
    localparam int K_PRESS = 0, K_REL = 1, K_REP = 2;
    // Raw edge driven at cycle c -> pulse sampled in c+24..c+33 (2 sync + 1 FSM entry + 3 ticks, tick phase free).
    localparam int LAT_LO = 24, LAT_HI = 33;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] key_raw = '1;
    logic [N-1:0] key_level, key_press, key_release, key_repeat, key_long;
    logic         tick_1ms;

    typedef struct { int kind; int key; int lo; int hi; } exp_t;
    exp_t sb[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    key_conditioner #(
        .N_KEYS(N), .CLK_HZ(10_000), .DEBOUNCE_MS(3), .LONG_MS(10), .REPEAT_MS(4), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_raw_i(key_raw),
        .key_level_o(key_level), .key_press_o(key_press), .key_release_o(key_release),
        .key_repeat_o(key_repeat), .key_long_o(key_long), .tick_1ms_o(tick_1ms)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        return (k == K_PRESS) ? "press" : (k == K_REL) ? "release" : "repeat";
    endfunction

    task automatic expect_ev(input int kind, input int key, input int lo, input int hi);
        exp_t e;
        e.kind = kind; e.key = key; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every pulse must consume a matching scoreboard entry; stale entries are misses.
    always @(negedge clk) begin
        logic [N-1:0] vec;
        int hit;
        for (int k = 0; k < 3; k++) begin
            vec = (k == K_PRESS) ? key_press : (k == K_REL) ? key_release : key_repeat;
            for (int b = 0; b < N; b++) begin
                if (vec[b]) begin
                    hit = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (hit < 0 && sb[i].kind == k && sb[i].key == b && cyc >= sb[i].lo && cyc <= sb[i].hi)
                            hit = i;
                    total++;
                    if (hit < 0) begin
                        bad++;
                        $display("FAIL unexpected_%s[%0d] at cycle %0d: actual=1 required=0", kind_name(k), b, cyc);
                    end else begin
                        sb.delete(hit);
                    end
                end
            end
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (cyc > sb[i].hi) begin
                total++;
                bad++;
                $display("FAIL missing_%s[%0d] window %0d..%0d: actual=0 required=1",
                         kind_name(sb[i].kind), sb[i].key, sb[i].lo, sb[i].hi);
                sb.delete(i);
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int r;
        int waited;

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_level", 32'(key_level), 0);
        check("reset_press", 32'(key_press), 0);
        check("reset_release", 32'(key_release), 0);
        check("reset_repeat", 32'(key_repeat), 0);
        check("reset_long", 32'(key_long), 0);
        check("reset_tick", 32'(tick_1ms), 0);
        rst_n = 1'b1;
        r = cyc;
        wait_until(r + 8);
        check("tick_before_terminal", 32'(tick_1ms), 0);
        wait_until(r + 9);
        check("tick_at_terminal", 32'(tick_1ms), 1);
        wait_until(r + 10);
        check("tick_one_wide", 32'(tick_1ms), 0);

        // Clean press on key 0, held 5 ms
        t = cyc;
        key_raw[0] = 1'b0;
        expect_ev(K_PRESS, 0, t + LAT_LO, t + LAT_HI);
        expect_ev(K_REP, 0, t + LAT_LO, t + LAT_HI);
        wait_until(t + 45);
        check("clean_level0", 32'(key_level[0]), 1);
        wait_until(t + 50);
        key_raw[0] = 1'b1;
        expect_ev(K_REL, 0, t + 50 + LAT_LO, t + 50 + LAT_HI);
        wait_until(t + 100);
        check("clean_level0_after_release", 32'(key_level[0]), 0);

        // Bounce on key 1: 15 clk stretches never survive 3 ticks
        for (int i = 0; i < 14; i++) begin
            key_raw[1] = ~key_raw[1];
            repeat (15) @(negedge clk);
            check("bounce_level1", 32'(key_level[1]), 0);
        end
        repeat (40) @(negedge clk);
        check("bounce_level1_end", 32'(key_level[1]), 0);

        // Long hold on key 2: repeats at accept, +100, +140, +180 clk
        t = cyc;
        key_raw[2] = 1'b0;
        expect_ev(K_PRESS, 2, t + LAT_LO, t + LAT_HI);
        expect_ev(K_REP, 2, t + LAT_LO, t + LAT_HI);
        expect_ev(K_REP, 2, t + LAT_LO + 100, t + LAT_HI + 100);
        expect_ev(K_REP, 2, t + LAT_LO + 140, t + LAT_HI + 140);
        expect_ev(K_REP, 2, t + LAT_LO + 180, t + LAT_HI + 180);
        wait_until(t + 120);
        check("long2_before_limit", 32'(key_long[2]), 0);
        wait_until(t + 140);
        check("long2_after_limit", 32'(key_long[2]), 1);
        wait_until(t + 230);
        key_raw[2] = 1'b1;
        expect_ev(K_REL, 2, t + 230 + LAT_LO, t + 230 + LAT_HI);
        wait_until(t + 280);
        check("long2_after_release", 32'(key_long[2]), 0);
        check("level2_after_release", 32'(key_level[2]), 0);

        // Keys 0 and 3 together; key 3 release leaves key 0 cadence intact
        t = cyc;
        key_raw[0] = 1'b0;
        key_raw[3] = 1'b0;
        expect_ev(K_PRESS, 0, t + LAT_LO, t + LAT_HI);
        expect_ev(K_REP, 0, t + LAT_LO, t + LAT_HI);
        expect_ev(K_PRESS, 3, t + LAT_LO, t + LAT_HI);
        expect_ev(K_REP, 3, t + LAT_LO, t + LAT_HI);
        expect_ev(K_REP, 0, t + LAT_LO + 100, t + LAT_HI + 100);
        expect_ev(K_REP, 0, t + LAT_LO + 140, t + LAT_HI + 140);
        waited = 0;
        while (!key_press[0] && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("press0_seen", 32'(key_press[0]), 1);
        check("press3_same_cycle", 32'(key_press[3]), 1);
        wait_until(t + 60);
        key_raw[3] = 1'b1;
        expect_ev(K_REL, 3, t + 60 + LAT_LO, t + 60 + LAT_HI);
        wait_until(t + 190);
        check("long0_during_cadence", 32'(key_long[0]), 1);
        key_raw[0] = 1'b1;
        expect_ev(K_REL, 0, t + 190 + LAT_LO, t + 190 + LAT_HI);
        wait_until(t + 240);
        check("levels_after_pair", 32'(key_level), 0);

        // Reset while key 1 is repeating, key still held afterwards
        t = cyc;
        key_raw[1] = 1'b0;
        expect_ev(K_PRESS, 1, t + LAT_LO, t + LAT_HI);
        expect_ev(K_REP, 1, t + LAT_LO, t + LAT_HI);
        expect_ev(K_REP, 1, t + LAT_LO + 100, t + LAT_HI + 100);
        wait_until(t + 150);
        check("long1_before_reset", 32'(key_long[1]), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_level", 32'(key_level), 0);
        check("async_reset_long", 32'(key_long), 0);
        check("async_reset_pulses", 32'({key_press, key_release, key_repeat}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        expect_ev(K_PRESS, 1, r + LAT_LO, r + LAT_HI);
        expect_ev(K_REP, 1, r + LAT_LO, r + LAT_HI);
        wait_until(r + 60);
        check("level1_after_reset", 32'(key_level[1]), 1);
        key_raw[1] = 1'b1;
        expect_ev(K_REL, 1, r + 60 + LAT_LO, r + 60 + LAT_HI);
        wait_until(r + 130);
        check("level1_final", 32'(key_level[1]), 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
